// File: rtl/binary_decrementer_serial.sv
// Bit-serial A-1 decrementer: one half-subtractor plus a borrow flop, LSB first.
// A start/busy/done handshake sequences it; z/Bout update only on the edge entering DONE.
module binary_decrementer_serial #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             Bout
);

    localparam int unsigned    IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0]  LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             borrow_q, borrow_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             bout_q, bout_d;
    logic             diff_bit;
    logic             borrow_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            work_q   <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            z_q      <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            borrow_q <= borrow_d;
            idx_q    <= idx_d;
            z_q      <= z_d;
            bout_q   <= bout_d;
        end
    end

    // Work register shifts right; each difference bit re-enters at the MSB,
    // so after WIDTH shifts it holds the full result in order.
    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        borrow_d   = borrow_q;
        idx_d      = idx_q;
        z_d        = z_q;
        bout_d     = bout_q;
        diff_bit   = work_q[0] ^ borrow_q;
        borrow_nxt = ~work_q[0] & borrow_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    work_d   = A;
                    borrow_d = 1'b1;
                    idx_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                work_d   = {diff_bit, work_q[WIDTH-1:1]};
                borrow_d = borrow_nxt;
                idx_d    = idx_q + IW'(1);
                if (idx_q == LAST) begin
                    z_d     = {diff_bit, work_q[WIDTH-1:1]};
                    bout_d  = borrow_nxt;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign z    = z_q;
    assign Bout = bout_q;

endmodule

// File: tb/tb_binary_decrementer_serial.sv
// Directed bench for binary_decrementer_serial at WIDTH=4 and WIDTH=8, with a
// per-instance arithmetic model checked every cycle plus literal expectations.
module tb_binary_decrementer_serial;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      start_v = '0;
    logic [1:0][7:0] a_v = '0;
    logic [1:0]      busy_v;
    logic [1:0]      done_v;
    logic [1:0][7:0] z_v;
    logic [1:0]      bout_v;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int unsigned W = (g == 0) ? 4 : 8;
        logic [W-1:0] z_w;
        logic         busy_w, done_w, bout_w;

        binary_decrementer_serial #(.WIDTH(W)) dut (
            .clk  (clk),
            .rst  (rst),
            .start(start_v[g]),
            .A    (a_v[g][W-1:0]),
            .busy (busy_w),
            .done (done_w),
            .z    (z_w),
            .Bout (bout_w)
        );

        assign busy_v[g] = busy_w;
        assign done_v[g] = done_w;
        assign z_v[g]    = 8'(z_w);
        assign bout_v[g] = bout_w;

        // Model: a pending result (A-1, A==0) is released after W busy cycles.
        int           m_cnt = 0;
        logic         m_done = 1'b0;
        logic [W-1:0] m_z = '0, p_z = '0;
        logic         m_b = 1'b0, p_b = 1'b0;

        always @(posedge clk) begin
            if (rst) begin
                m_cnt = 0; m_done = 1'b0; m_z = '0; m_b = 1'b0;
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_done = 1'b1; m_z = p_z; m_b = p_b;
                end
            end else if (start_v[g]) begin
                m_cnt = W;
                p_z   = a_v[g][W-1:0] - W'(1);
                p_b   = (a_v[g][W-1:0] == '0);
            end
        end

        always @(negedge clk) begin
            check($sformatf("busy%0d", W), 8'(busy_w), 8'(m_cnt > 0));
            check($sformatf("done%0d", W), 8'(done_w), 8'(m_done));
            check($sformatf("z%0d", W),    8'(z_w),    8'(m_z));
            check($sformatf("bout%0d", W), 8'(bout_w), 8'(m_b));
        end
    end

    // One operation on instance i; counts busy cycles and checks literal results.
    task automatic run_op(input int i, input int w, input logic [7:0] a,
                          input logic [7:0] exp_z, input logic exp_b);
        int nbusy = 0;
        bit got = 0;
        @(posedge clk); #1;
        start_v[i] = 1'b1; a_v[i] = a;
        @(posedge clk); #1;
        start_v[i] = 1'b0; a_v[i] = ~a;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            if (busy_v[i]) nbusy++;
            if (done_v[i]) got = 1;
            a_v[i] = 8'($urandom);
        end
        check("done_seen", 8'(got), 8'd1);
        check("busy_len", 8'(nbusy), 8'(w));
        check("z_lit", z_v[i], exp_z);
        check("bout_lit", 8'(bout_v[i]), 8'(exp_b));
    endtask

    initial begin
        int last_done;
        int ndone;
        bit saw_done;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_z4", z_v[0], 8'h00);
        check("rst_busy4", 8'(busy_v[0]), 8'h00);

        run_op(0, 4, 8'h05, 8'h04, 1'b0);
        run_op(0, 4, 8'h08, 8'h07, 1'b0);
        run_op(0, 4, 8'h00, 8'h0F, 1'b1);
        run_op(0, 4, 8'h0F, 8'h0E, 1'b0);

        // start held high: one done every 6 cycles, each z=0010
        @(posedge clk); #1;
        start_v[0] = 1'b1; a_v[0] = 8'h03;
        last_done = -1; ndone = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done_v[0]) begin
                if (last_done >= 0) check("done_gap", 8'(c - last_done), 8'd6);
                check("held_z", z_v[0], 8'h02);
                last_done = c; ndone++;
            end
        end
        check("held_ndone", 8'(ndone), 8'd5);
        @(posedge clk); #1 start_v[0] = 1'b0;
        repeat (8) @(posedge clk);

        // reset two cycles after accept aborts the operation
        #1 start_v[0] = 1'b1; a_v[0] = 8'h0A;
        @(posedge clk); #1 start_v[0] = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        saw_done = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done_v[0]) saw_done = 1;
        end
        check("abort_nodone", 8'(saw_done), 8'd0);
        check("abort_busy", 8'(busy_v[0]), 8'd0);
        check("abort_z", z_v[0], 8'h00);
        check("abort_bout", 8'(bout_v[0]), 8'd0);
        run_op(0, 4, 8'h01, 8'h00, 1'b0);

        run_op(1, 8, 8'h00, 8'hFF, 1'b1);
        run_op(1, 8, 8'h80, 8'h7F, 1'b0);
        run_op(1, 8, 8'h01, 8'h00, 1'b0);
        run_op(1, 8, 8'hA5, 8'hA4, 1'b0);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/binary_decrementer_serial.md
# binary_decrementer_serial

Sequential 4-bit (parameterizable) binary decrementer computing z = A − 1 bit-serially, one bit per clock, LSB first, using a single half-subtractor cell and a borrow flip-flop. It is the counterpart of the lab's combinational binary incrementer. It serves as the decrement path for register/counter experiments in the Computer Architecture lab, where a start/busy/done handshake sequences it from a control unit.

## Interface
Parameters:
- WIDTH, 4, operand and result width in bits (≥ 2)

Ports:
- clk  input  1  rising-edge clock; the block's only clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  request a decrement of A; sampled only in IDLE
- A  input  WIDTH  operand; captured on the accepting edge, free to change afterwards
- busy  output  1  high while a decrement is in progress
- done  output  1  one-cycle pulse: z and Bout are valid and updated
- z  output  WIDTH  result A − 1 (mod 2^WIDTH); held until the next completion
- Bout  output  1  final borrow: 1 only when A was 0 (result wrapped to all ones)

## Operation
- States: IDLE, SHIFT, DONE. Encoding is free.
- IDLE: busy=0, done=0.
  - On start=1: capture A into the work register, set borrow=1 (the constant subtrahend 1), set bit index=0, and go to SHIFT.
  - On start=0: stay in IDLE.
- SHIFT: each cycle processes bit i = index:
  - result bit i = a_i XOR borrow
  - next borrow = (NOT a_i) AND borrow
  - index increments.
  - After bit WIDTH−1, go to DONE. Fixed latency, no early exit when borrow clears.
- DONE:
  - Transfer the work result to z and the final borrow to Bout.
  - done=1 for this cycle only.
  - Go to IDLE unconditionally.
- z and Bout change only on the edge entering DONE. They are stable at all other times, including throughout SHIFT.
- start asserted in SHIFT or DONE is ignored. There is no queuing. The bench must re-assert start in IDLE.
- Arithmetic is modulo 2^WIDTH: 0 − 1 = all ones with Bout=1. For every other A, Bout=0.
- Reset (rst=1 at a clock edge), from any state:
  - state=IDLE, busy=0, done=0, z=0, Bout=0.
  - work register, borrow and index are cleared.
  - Reset wins over start on the same edge.
  - A reset during SHIFT aborts the operation with no done pulse. z keeps its reset value 0.

## Timing
- Reset values: busy=0, done=0, z=0, Bout=0, state IDLE.
- Let edge E be the edge that samples start=1 in IDLE:
  - after E: SHIFT, busy=1, index=0
  - after E+k, k=1..WIDTH: bit k−1 processed
  - after E+WIDTH: DONE, busy=0, done=1, z/Bout valid
  - after E+WIDTH+1: IDLE, done=0
- busy is high for exactly WIDTH cycles. Start-to-done latency is WIDTH edges. The minimum repeat interval is WIDTH+2 cycles, because the earliest next accept is edge E+WIDTH+2.
- busy and done are never high together, and done never occurs without a preceding busy period.
- A may change on any cycle after E without affecting the result.

## Test plan
- Reset then idle: rst=1 for 2 cycles, start=0 → busy=0, done=0, z=4'b0000, Bout=0 indefinitely.
- A=4'b0101, start for one cycle → busy high 4 cycles, done pulse on the 4th edge after accept, z=4'b0100, Bout=0, z unchanged during busy.
- Borrow ripple and wrap: A=4'b1000 → z=4'b0111, Bout=0. A=4'b0000 → z=4'b1111, Bout=1.
- start held high continuously with A=4'b0011 → accepts only in IDLE; done pulses every 6 cycles; each result z=4'b0010. start pulses during SHIFT/DONE produce no extra operations.
- Reset mid-operation: A=4'b1010 accepted, rst=1 two cycles later → no done pulse, busy=0, z=0, Bout=0. A following start with A=4'b0001 yields z=4'b0000, Bout=0.
- WIDTH=8 instance: A=8'h00 → z=8'hFF, Bout=1 after 8 busy cycles. A=8'h80 → z=8'h7F, Bout=0.
